// File: rtl/core_ctrl_seq_if.sv
// Bus bundle between the core sequencer and its line memory, instruction memory,
// data RAM and ALU. The core uses the master modport; the memories/ALU use slave.
interface core_ctrl_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 8,
  parameter int OPC_W  = 8,
  parameter int CNT_W  = 16
);
  logic [4*ADDR_W-1:0] line;
  logic [IP_W-1:0]     ip;
  logic                line_mem_en;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   instr_addr;
  logic                instr_mem_en;
  logic                ram_busy;
  logic [DATA_W-1:0]   data_rd;
  logic [DATA_W-1:0]   data_wr;
  logic [ADDR_W-1:0]   addr_rd;
  logic [ADDR_W-1:0]   addr_wr;
  logic                ram_rd_en;
  logic                ram_wr_en;
  logic [DATA_W-1:0]   value1;
  logic [DATA_W-1:0]   value2;
  logic [ADDR_W-1:0]   addr1;
  logic [ADDR_W-1:0]   addr2;
  logic [DATA_W-1:0]   result;
  logic                update_ip;
  logic                alu_en;
  logic                ip_update_en;
  logic                halted;
  logic [CNT_W-1:0]    retire_cnt;

  modport master (
    input  line, opcode, ram_busy, data_rd, result, update_ip,
    output ip, line_mem_en, instr_addr, instr_mem_en, data_wr, addr_rd, addr_wr,
           ram_rd_en, ram_wr_en, value1, value2, addr1, addr2, alu_en,
           ip_update_en, halted, retire_cnt
  );

  modport slave (
    output line, opcode, ram_busy, data_rd, result, update_ip,
    input  ip, line_mem_en, instr_addr, instr_mem_en, data_wr, addr_rd, addr_wr,
           ram_rd_en, ram_wr_en, value1, value2, addr1, addr2, alu_en,
           ip_update_en, halted, retire_cnt
  );
endinterface

// File: rtl/core_ctrl_seq.sv
// CPU core controller with folded-in instruction sequencer: fetch line, look up
// opcode, read two RAM operands (with wait states), execute, write back, advance IP.
//
// state    | meaning
// FETCH    | line memory read at ip
// DECODE   | latch line, instr memory read at iaddr field
// RQ1      | latch opcode, RAM read request for src1
// RW1      | wait for src1 data
// RQ2      | RAM read request for src2
// RW2      | wait for src2 data
// EXEC     | ALU cycle; branch class retires here, HALT opcode stops here
// WB       | RAM write of result, held until accepted, then retire
// HALT     | core stopped until reset
module core_ctrl_seq #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 8,
  parameter int              IP_W     = 8,
  parameter int              OPC_W    = 8,
  parameter int              NOWR_BIT = 6,
  parameter logic [OPC_W-1:0] HALT_OPC = {OPC_W{1'b1}},
  parameter int              CNT_W    = 16
) (
  input logic            clk,
  input logic            rstn,
  core_ctrl_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RQ1, S_RW1, S_RQ2, S_RW2, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t              state_q;
  logic [3*ADDR_W-1:0] line_q;
  logic [OPC_W-1:0]    opc_q;
  logic [IP_W-1:0]     ip_q;
  logic [DATA_W-1:0]   value1_q;
  logic [DATA_W-1:0]   value2_q;
  logic [ADDR_W-1:0]   addr_rd_q;
  logic [ADDR_W-1:0]   addr_wr_q;
  logic [DATA_W-1:0]   data_wr_q;
  logic [CNT_W-1:0]    retire_q;

  logic [ADDR_W-1:0]   dst_d;
  logic [ADDR_W-1:0]   src1_d;
  logic [ADDR_W-1:0]   src2_d;
  logic                is_halt_d;

  assign dst_d     = line_q[3*ADDR_W-1:2*ADDR_W];
  assign src1_d    = line_q[2*ADDR_W-1:ADDR_W];
  assign src2_d    = line_q[ADDR_W-1:0];
  assign is_halt_d = (opc_q == HALT_OPC);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      line_q    <= '0;
      opc_q     <= '0;
      ip_q      <= '0;
      value1_q  <= '0;
      value2_q  <= '0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      retire_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          line_q    <= bus.line[3*ADDR_W-1:0];
          addr_rd_q <= bus.line[2*ADDR_W-1:ADDR_W];
          state_q   <= S_RQ1;
        end
        S_RQ1: begin
          opc_q   <= bus.opcode;
          state_q <= S_RW1;
        end
        S_RW1: begin
          if (!bus.ram_busy) begin
            value1_q  <= bus.data_rd;
            addr_rd_q <= src2_d;
            state_q   <= S_RQ2;
          end
        end
        S_RQ2: state_q <= S_RW2;
        S_RW2: begin
          if (!bus.ram_busy) begin
            value2_q <= bus.data_rd;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_halt_d) begin
            state_q <= S_HALT;
          end else begin
            data_wr_q <= bus.result;
            addr_wr_q <= dst_d;
            // Branch/compare class retires here; write class ignores update_ip.
            if (opc_q[NOWR_BIT]) begin
              ip_q     <= bus.update_ip ? dst_d[IP_W-1:0] : ip_q + IP_W'(1);
              retire_q <= retire_q + CNT_W'(1);
              state_q  <= S_FETCH;
            end else begin
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          if (!bus.ram_busy) begin
            ip_q     <= ip_q + IP_W'(1);
            retire_q <= retire_q + CNT_W'(1);
            state_q  <= S_FETCH;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // FETCH is the reset state, so the line strobe is masked while reset is held.
  assign bus.line_mem_en  = (state_q == S_FETCH) && rstn;
  assign bus.instr_mem_en = (state_q == S_DECODE);
  assign bus.instr_addr   = bus.line[4*ADDR_W-1:3*ADDR_W];
  assign bus.ram_rd_en    = (state_q == S_RQ1) || (state_q == S_RQ2);
  assign bus.ram_wr_en    = (state_q == S_WB);
  assign bus.alu_en       = (state_q == S_EXEC) && !is_halt_d;
  assign bus.ip_update_en = ((state_q == S_EXEC) && !is_halt_d && opc_q[NOWR_BIT])
                          || ((state_q == S_WB) && !bus.ram_busy);
  assign bus.halted       = (state_q == S_HALT);

  assign bus.ip         = ip_q;
  assign bus.addr_rd    = addr_rd_q;
  assign bus.addr_wr    = addr_wr_q;
  assign bus.data_wr    = data_wr_q;
  assign bus.value1     = value1_q;
  assign bus.value2     = value2_q;
  assign bus.addr1      = src1_d;
  assign bus.addr2      = src2_d;
  assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Bench for core_ctrl_seq: memories and ALU modelled around the bus, table vectors,
// hand-written corner sequences, and a random program checked against an ISA-level model.
module tb_core_ctrl_seq;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  core_ctrl_seq_if bus ();
  core_ctrl_seq dut (.clk(clk), .rstn(rstn), .bus(bus.master));

  logic [31:0] lmem [256];
  logic [7:0]  imem [256];
  logic [7:0]  ram  [256];
  logic [7:0]  mram [256];

  int n_chk = 0;
  int n_pass = 0;
  int n_overlap = 0;

  logic s_ipu, s_alu, s_wacc;

  function automatic logic [7:0] alu_f(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign bus.result    = bus.alu_en ? alu_f(bus.opcode, bus.value1, bus.value2) : 8'h00;
  assign bus.update_ip = bus.alu_en && (bus.value1 < bus.value2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive busy, observe, then let the memories respond.
  task automatic cyc(input bit busy);
    logic        lreq, ireq, rreq, wacc;
    logic [7:0]  lad, iad, rad, wad, wdat;
    bus.ram_busy = busy;
    #1;
    s_ipu  = bus.ip_update_en;
    s_alu  = bus.alu_en;
    s_wacc = bus.ram_wr_en && !busy;
    if (bus.ram_rd_en && bus.ram_wr_en) n_overlap++;
    lreq = bus.line_mem_en;  lad = bus.ip;
    ireq = bus.instr_mem_en; iad = bus.instr_addr;
    rreq = bus.ram_rd_en;    rad = bus.addr_rd;
    wacc = s_wacc;           wad = bus.addr_wr; wdat = bus.data_wr;
    @(posedge clk);
    #1;
    if (lreq) bus.line    = lmem[lad];
    if (ireq) bus.opcode  = imem[iad];
    if (rreq) bus.data_rd = ram[rad];
    if (wacc) ram[wad]    = wdat;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check);
    rstn = 1'b0;
    bus.ram_busy = 1'b0;
    bus.line = '0; bus.opcode = '0; bus.data_rd = '0;
    @(negedge clk);
    #1;
    if (check) begin
      chk("rst_strobes", {bus.line_mem_en, bus.instr_mem_en, bus.ram_rd_en, bus.ram_wr_en,
                          bus.alu_en, bus.ip_update_en, bus.halted}, 64'd0);
      chk("rst_ip", bus.ip, 64'd0);
      chk("rst_retire", bus.retire_cnt, 64'd0);
      chk("rst_data", {bus.value1, bus.value2, bus.data_wr, bus.addr_rd, bus.addr_wr}, 64'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_one(input logic [31:0] mask, output int cycles, output int wacc,
                         output int alun, output bit done);
    cycles = 0; wacc = 0; alun = 0; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      cyc(c < 32 ? mask[c] : 1'b0);
      wacc += int'(s_wacc);
      alun += int'(s_alu);
      if (s_ipu) begin
        cycles = c + 1;
        done = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  opc, dst, r1, r2;
    logic [31:0] mask;
    int          ncyc;
    logic [7:0]  eip, emem;
    int          ewacc;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cycles, wacc, alun, extra, retired;
    bit done;
    logic [31:0] ln;
    logic [7:0]  mip, op, v1, v2;
    logic [15:0] mret;

    // opc dst r1 r2 busy-mask cycles ip ram[dst] wr-accepts
    vt[0] = '{8'h00, 8'h10, 8'h03, 8'h04, 32'h0000_0000, 8,  8'h01, 8'h07, 1};
    vt[1] = '{8'h00, 8'h10, 8'h03, 8'h04, 32'h0000_0C38, 13, 8'h01, 8'h07, 1};
    vt[2] = '{8'h40, 8'h05, 8'h03, 8'h04, 32'h0000_0000, 7,  8'h05, 8'hAA, 0};
    vt[3] = '{8'h40, 8'h05, 8'h04, 8'h03, 32'h0000_0000, 7,  8'h01, 8'hAA, 0};
    vt[4] = '{8'h01, 8'h10, 8'h09, 8'h04, 32'h0000_0020, 9,  8'h01, 8'h05, 1};
    vt[5] = '{8'h42, 8'h07, 8'h03, 8'h04, 32'h0000_0005, 7,  8'h07, 8'hAA, 0};
    vt[6] = '{8'h02, 8'h10, 8'h5A, 8'h0F, 32'h0000_0080, 9,  8'h01, 8'h55, 1};
    vt[7] = '{8'h03, 8'h30, 8'hF0, 8'h3C, 32'h0000_0FF8, 17, 8'h01, 8'h30, 1};

    for (int i = 0; i < 256; i++) begin
      lmem[i] = '0; imem[i] = '0; ram[i] = '0;
    end

    foreach (vt[i]) begin
      lmem[0] = {8'h00, vt[i].dst, 8'h01, 8'h02};
      lmem[1] = {8'h00, 8'h00, 8'h00, 8'h00};
      imem[0] = vt[i].opc;
      ram[1] = vt[i].r1; ram[2] = vt[i].r2; ram[vt[i].dst] = 8'hAA;
      do_reset(i == 0);
      run_one(vt[i].mask, cycles, wacc, alun, done);
      chk($sformatf("v%0d_done", i), done, 64'd1);
      chk($sformatf("v%0d_cycles", i), cycles, vt[i].ncyc);
      chk($sformatf("v%0d_ip", i), bus.ip, vt[i].eip);
      chk($sformatf("v%0d_ram", i), ram[vt[i].dst], vt[i].emem);
      chk($sformatf("v%0d_values", i), {bus.value1, bus.value2}, {vt[i].r1, vt[i].r2});
      chk($sformatf("v%0d_addrs", i), {bus.addr1, bus.addr2}, 16'h0102);
      chk($sformatf("v%0d_wacc", i), wacc, vt[i].ewacc);
      chk($sformatf("v%0d_alu", i), alun, 64'd1);
      chk($sformatf("v%0d_retire", i), bus.retire_cnt, 64'd1);
    end

    // ip wraps from 0xFF to 0x00 on a write instruction
    lmem[0]    = {8'h00, 8'hFF, 8'h01, 8'h02};
    imem[0]    = 8'h40;
    lmem[8'hFF] = {8'h01, 8'h20, 8'h01, 8'h02};
    imem[1]    = 8'h00;
    ram[1] = 8'h03; ram[2] = 8'h04; ram[8'h20] = 8'hAA;
    do_reset(1'b0);
    run_one(32'h0, cycles, wacc, alun, done);
    chk("wrap_ip_ff", bus.ip, 64'hFF);
    run_one(32'h80, cycles, wacc, alun, done);
    chk("wrap_cycles", cycles, 64'd9);
    chk("wrap_ip", bus.ip, 64'h00);
    chk("wrap_ram", ram[8'h20], 64'h07);
    chk("wrap_retire", bus.retire_cnt, 64'd2);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1'b0);
      extra += int'(s_ipu);
    end
    chk("wrap_ipu_once", extra, 64'd0);

    // HALT at ip=3
    lmem[0] = {8'h00, 8'h03, 8'h01, 8'h02};
    imem[0] = 8'h40;
    lmem[3] = {8'h02, 8'h00, 8'h01, 8'h02};
    imem[2] = 8'hFF;
    do_reset(1'b0);
    run_one(32'h0, cycles, wacc, alun, done);
    chk("halt_pre_ip", bus.ip, 64'h03);
    alun = 0; extra = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(c[0]);
      alun += int'(s_alu);
      extra += int'(s_ipu);
    end
    chk("halt_halted", bus.halted, 64'd1);
    chk("halt_alu", alun, 64'd0);
    chk("halt_ipu", extra, 64'd0);
    chk("halt_ip", bus.ip, 64'h03);
    chk("halt_retire", bus.retire_cnt, 64'd1);
    chk("halt_strobes", {bus.line_mem_en, bus.instr_mem_en, bus.ram_rd_en, bus.ram_wr_en}, 64'd0);

    // Reset while a write is pending in WB
    lmem[0] = {8'h00, 8'h10, 8'h01, 8'h02};
    imem[0] = 8'h00;
    ram[8'h10] = 8'hAA;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) cyc(c >= 7);
    bus.ram_busy = 1'b1;
    #1;
    chk("rstwb_wr_before", bus.ram_wr_en, 64'd1);
    rstn = 1'b0;
    #1;
    chk("rstwb_wr_dropped", bus.ram_wr_en, 64'd0);
    @(negedge clk);
    bus.ram_busy = 1'b0;
    rstn = 1'b1;
    #1;
    chk("rstwb_fetch", {bus.line_mem_en, bus.ip}, {1'b1, 8'h00});
    chk("rstwb_no_write", ram[8'h10], 64'hAA);
    @(negedge clk);

    // Random program against an instruction-level model
    for (int i = 0; i < 256; i++) begin
      lmem[i] = $urandom;
      imem[i] = 8'($urandom_range(0, 254));
      ram[i]  = 8'($urandom);
      mram[i] = ram[i];
    end
    mip = 8'h00; mret = 16'h0000; retired = 0;
    do_reset(1'b0);
    for (int c = 0; c < 8000 && retired < 300; c++) begin
      cyc($urandom_range(0, 3) == 0);
      if (s_ipu) begin
        ln = lmem[mip];
        op = imem[ln[31:24]];
        v1 = mram[ln[15:8]];
        v2 = mram[ln[7:0]];
        if (op[6]) mip = (v1 < v2) ? ln[23:16] : mip + 8'd1;
        else begin
          mram[ln[23:16]] = alu_f(op, v1, v2);
          mip = mip + 8'd1;
        end
        mret = mret + 16'd1;
        retired++;
        chk("rand_ip", bus.ip, mip);
        chk("rand_retire", bus.retire_cnt, mret);
      end
    end
    chk("rand_progress", retired, 64'd300);
    extra = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mram[i]) extra++;
    chk("rand_ram_image", extra, 64'd0);
    chk("rd_wr_overlap", n_overlap, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
